// File: rtl/alu_mc_core.sv
`default_nettype none
// ============================================================================
//  Module   : alu_mc_core
//  Purpose  : Parametrised multi-cycle ALU with valid/ready handshakes on both
//             sides, iterative restoring divider with divide-by-zero report,
//             barrel shifts and registered result/flag outputs.
//  Options  : ALU_SIGNED_EN - adds SIGNED input selecting two's-complement
//             compares, arithmetic SHR and sign-extended SUB.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_mc_core #(
    parameter int WIDTH = 16
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [3:0]           ALU_FUN,
`ifdef ALU_SIGNED_EN
    input  logic                 SIGNED,
`endif
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic [2*WIDTH-1:0]   ALU_OUT,
    output logic                 ARITH_FLAG,
    output logic                 LOGIC_FLAG,
    output logic                 CMP_FLAG,
    output logic                 SHIFT_FLAG,
    output logic                 DIV_BY_ZERO
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH);
    localparam int DW  = 2 * WIDTH;

    // flag vector layout: {div_by_zero, shift, cmp, logic, arith}
    localparam logic [4:0] FL_ARITH = 5'b00001;
    localparam logic [4:0] FL_LOGIC = 5'b00010;
    localparam logic [4:0] FL_CMP   = 5'b00100;
    localparam logic [4:0] FL_SHIFT = 5'b01000;
    localparam logic [4:0] FL_DBZ   = 5'b10000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  rem_q, rem_d;
    logic [WIDTH-1:0]  quo_q, quo_d;
    logic [WIDTH-1:0]  dsr_q, dsr_d;
    logic              out_valid_q, out_valid_d;
    logic [DW-1:0]     alu_out_q, alu_out_d;
    logic [4:0]        flags_q, flags_d;
    logic              rdy_en_q;

    logic              use_signed;
    logic [SHW-1:0]    sh;
    logic [WIDTH:0]    diff;
    logic [WIDTH-1:0]  shr_v;
    logic              a_gt, a_lt;
    logic [DW-1:0]     res;
    logic [4:0]        res_flags;
    logic [WIDTH:0]    rem_sh, trial;
    logic              take;
    logic              slot_free, in_ready, accept, long_div;

`ifdef ALU_SIGNED_EN
    assign use_signed = SIGNED;
`else
    assign use_signed = 1'b0;
`endif

    assign sh = B[SHW-1:0];

    // Single-cycle result and class flags for the operation presented at the inputs
    always_comb begin
        res       = '0;
        res_flags = '0;
        if (use_signed) begin
            diff  = {A[WIDTH-1], A} - {B[WIDTH-1], B};
            shr_v = $unsigned($signed(A) >>> sh);
            a_gt  = $signed(A) > $signed(B);
            a_lt  = $signed(A) < $signed(B);
        end else begin
            diff  = {1'b0, A} - {1'b0, B};
            shr_v = A >> sh;
            a_gt  = A > B;
            a_lt  = A < B;
        end
        case (ALU_FUN)
            4'd0:  begin res = {{(WIDTH-1){1'b0}}, {1'b0, A} + {1'b0, B}};       res_flags = FL_ARITH; end
            // the WIDTH+1-bit difference sign-extended equals the modular result
            4'd1:  begin res = {{(WIDTH-1){diff[WIDTH]}}, diff};                   res_flags = FL_ARITH; end
            4'd2:  begin res = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};            res_flags = FL_ARITH; end
            // only used when B==0; a non-zero divisor runs through the iterative path
            4'd3:  begin
                res       = {A, {WIDTH{1'b1}}};
                res_flags = (B == '0) ? (FL_ARITH | FL_DBZ) : FL_ARITH;
            end
            4'd4:  begin res = {{WIDTH{1'b0}}, A & B};        res_flags = FL_LOGIC; end
            4'd5:  begin res = {{WIDTH{1'b0}}, A | B};        res_flags = FL_LOGIC; end
            4'd6:  begin res = {{WIDTH{1'b0}}, ~(A & B)};     res_flags = FL_LOGIC; end
            4'd7:  begin res = {{WIDTH{1'b0}}, ~(A | B)};     res_flags = FL_LOGIC; end
            4'd8:  begin res = {{WIDTH{1'b0}}, A ^ B};        res_flags = FL_LOGIC; end
            4'd9:  begin res = {{WIDTH{1'b0}}, ~(A ^ B)};     res_flags = FL_LOGIC; end
            4'd10: begin res = {{(DW-1){1'b0}}, A == B};      res_flags = FL_CMP;   end
            4'd11: begin res = {{(DW-2){1'b0}}, a_gt, 1'b0};  res_flags = FL_CMP;   end
            4'd12: begin res = {{(DW-2){1'b0}}, a_lt, a_lt};  res_flags = FL_CMP;   end
            4'd13: begin res = {{WIDTH{1'b0}}, shr_v};        res_flags = FL_SHIFT; end
            4'd14: begin res = {{WIDTH{1'b0}}, A << sh};      res_flags = FL_SHIFT; end
            default: begin res = '0;                          res_flags = '0;       end
        endcase
    end

    // One restoring-division step: shift in the next dividend bit, subtract if it fits
    always_comb begin
        rem_sh = {rem_q, quo_q[WIDTH-1]};
        trial  = rem_sh - {1'b0, dsr_q};
        take   = ~trial[WIDTH];
    end

    assign slot_free = ~out_valid_q | OUT_READY;
    assign in_ready  = rdy_en_q & (state_q == S_IDLE) & slot_free;
    assign accept    = IN_VALID & in_ready;
    assign long_div  = (ALU_FUN == 4'd3) && (B != '0);

    // Next-state, divider datapath and output-slot control
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dsr_d       = dsr_q;
        alu_out_d   = alu_out_q;
        flags_d     = flags_q;
        out_valid_d = out_valid_q & ~OUT_READY;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (long_div) begin
                        state_d = S_DIV;
                        cnt_d   = '0;
                        rem_d   = '0;
                        quo_d   = A;
                        dsr_d   = B;
                    end else begin
                        out_valid_d = 1'b1;
                        alu_out_d   = res;
                        flags_d     = res_flags;
                    end
                end
            end
            S_DIV: begin
                rem_d = take ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], take};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // wait here rather than overwrite a result the consumer has not taken
                if (slot_free) begin
                    out_valid_d = 1'b1;
                    alu_out_d   = {rem_q, quo_q};
                    flags_d     = FL_ARITH;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; rdy_en_q keeps IN_READY low until after reset release
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dsr_q       <= '0;
            out_valid_q <= 1'b0;
            alu_out_q   <= '0;
            flags_q     <= '0;
            rdy_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dsr_q       <= dsr_d;
            out_valid_q <= out_valid_d;
            alu_out_q   <= alu_out_d;
            flags_q     <= flags_d;
            rdy_en_q    <= 1'b1;
        end
    end

    assign IN_READY    = in_ready;
    assign OUT_VALID   = out_valid_q;
    assign ALU_OUT     = alu_out_q;
    assign ARITH_FLAG  = flags_q[0];
    assign LOGIC_FLAG  = flags_q[1];
    assign CMP_FLAG    = flags_q[2];
    assign SHIFT_FLAG  = flags_q[3];
    assign DIV_BY_ZERO = flags_q[4];

endmodule
`default_nettype wire
